// File: rtl/cdb_fair_arbiter.sv
// cdb_fair_arbiter: shares N CDB ports among NUM_REQ requesters with urgent-first, rotating-priority selection.
// Optional perf counters are built only when CDB_ARB_PERF_EN is defined.
module cdb_fair_arbiter #(
   parameter int NUM_REQ      = 6,
   parameter int N            = 3,
   parameter int STARVE_LIMIT = 4,
   parameter int ROTATE       = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [N-1:0][NUM_REQ-1:0] gnt_bus,
   output logic [NUM_REQ-1:0]        urgent,
   output logic [31:0]               perf_grants,
   output logic [31:0]               perf_starve
);
   localparam int AW = $clog2(STARVE_LIMIT + 1);
   localparam int PW = $clog2(NUM_REQ);
   logic [AW-1:0]             age [NUM_REQ];
   logic [PW-1:0]             rr_ptr, rr_nxt;
   logic [N-1:0][NUM_REQ-1:0] port;
   int                        cnt, start, idx;
   always_comb begin
      urgent = '0;
      port   = '0;
      gnt    = '0;
      rr_nxt = rr_ptr;
      cnt    = 0;
      idx    = 0;
      start  = ROTATE != 0 ? int'(rr_ptr) : 0;
      for (int i = 0; i < NUM_REQ; i++)
         urgent[i] = !reset && req[i] && age[i] == AW'(STARVE_LIMIT);
      for (int i = 0; i < NUM_REQ; i++)
         if (urgent[i] && cnt < N) begin
            for (int k = 0; k < N; k++)
               if (cnt == k) port[k][i] = 1'b1;
            cnt = cnt + 1;
         end
      // second pass walks from the pointer; only one i matches each position j
      for (int j = 0; j < NUM_REQ; j++) begin
         idx = (start + j) % NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++)
            if (i == idx && !reset && req[i] && !urgent[i] && cnt < N) begin
               for (int k = 0; k < N; k++)
                  if (cnt == k) port[k][i] = 1'b1;
               rr_nxt = PW'((i + 1) % NUM_REQ);
               cnt = cnt + 1;
            end
      end
      for (int k = 0; k < N; k++)
         gnt = gnt | port[k];
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++)
            age[i] <= '0;
         rr_ptr  <= '0;
         gnt_bus <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            age[i] <= (req[i] && !gnt[i]) ? (age[i] == AW'(STARVE_LIMIT) ? age[i] : age[i] + 1'b1) : '0;
         rr_ptr  <= rr_nxt;
         gnt_bus <= port;
      end
   end
`ifdef CDB_ARB_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_grants <= '0;
         perf_starve <= '0;
      end else begin
         perf_grants <= perf_grants + 32'($countones(gnt));
         perf_starve <= perf_starve + {31'b0, |urgent};
      end
   end
`else
   assign perf_grants = '0;
   assign perf_starve = '0;
`endif
endmodule

// File: tb/tb_cdb_fair_arbiter.sv
// tb_cdb_fair_arbiter: four arbiter configurations checked against a queue-based selection model.
module tb_cdb_fair_arbiter;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] req   = '0;
   int         errors = 0;
   int         checks = 0;
   always #5 clock = ~clock;
   logic [5:0]       g6 [3];
   logic [5:0]       u6 [3];
   logic [2:0][5:0]  b6 [3];
   logic [7:0]       g8, u8;
   logic [2:0][7:0]  b8;
   logic [31:0]      pg [4];
   logic [31:0]      ps [4];
   cdb_fair_arbiter #(.NUM_REQ(6), .N(3), .STARVE_LIMIT(4), .ROTATE(1)) u0 (
      .clock(clock), .reset(reset), .req(req[5:0]), .gnt(g6[0]), .gnt_bus(b6[0]),
      .urgent(u6[0]), .perf_grants(pg[0]), .perf_starve(ps[0]));
   cdb_fair_arbiter #(.NUM_REQ(6), .N(3), .STARVE_LIMIT(4), .ROTATE(0)) u1 (
      .clock(clock), .reset(reset), .req(req[5:0]), .gnt(g6[1]), .gnt_bus(b6[1]),
      .urgent(u6[1]), .perf_grants(pg[1]), .perf_starve(ps[1]));
   cdb_fair_arbiter #(.NUM_REQ(6), .N(3), .STARVE_LIMIT(1), .ROTATE(0)) u2 (
      .clock(clock), .reset(reset), .req(req[5:0]), .gnt(g6[2]), .gnt_bus(b6[2]),
      .urgent(u6[2]), .perf_grants(pg[2]), .perf_starve(ps[2]));
   cdb_fair_arbiter #(.NUM_REQ(8), .N(3), .STARVE_LIMIT(1), .ROTATE(0)) u3 (
      .clock(clock), .reset(reset), .req(req), .gnt(g8), .gnt_bus(b8),
      .urgent(u8), .perf_grants(pg[3]), .perf_starve(ps[3]));
   int cfg_nr  [4] = '{6, 6, 6, 8};
   int cfg_sl  [4] = '{4, 4, 1, 1};
   int cfg_rot [4] = '{1, 0, 0, 0};
   int              m_age [4][8];
   int              m_ptr [4];
   logic [2:0][7:0] m_bus [4];
   logic [31:0]     m_pg  [4];
   logic [31:0]     m_ps  [4];
   logic [7:0]      e_g   [4];
   logic [7:0]      e_u   [4];
   logic [2:0][7:0] e_p   [4];
   int              e_l   [4];
   task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask
   // urgent requesters ascending, then the rest from the pointer; first three get ports 0..2
   function automatic void model_eval(input int d, input logic [7:0] r, input logic rst,
                                      output logic [7:0] g, output logic [7:0] u,
                                      output logic [2:0][7:0] p, output int last);
      int sel[$];
      int nr, nu, st, idx;
      g = '0; u = '0; p = '0; last = -1;
      nr = cfg_nr[d];
      if (!rst) begin
         for (int i = 0; i < nr; i++)
            if (r[i] && m_age[d][i] == cfg_sl[d]) begin
               u[i] = 1'b1;
               sel.push_back(i);
            end
         nu = sel.size();
         st = cfg_rot[d] != 0 ? m_ptr[d] : 0;
         for (int j = 0; j < nr; j++) begin
            idx = (st + j) % nr;
            if (r[idx] && !u[idx]) sel.push_back(idx);
         end
         for (int k = 0; k < 3 && k < sel.size(); k++) begin
            p[k][sel[k]] = 1'b1;
            g[sel[k]] = 1'b1;
            if (k >= nu) last = sel[k];
         end
      end
   endfunction
   task automatic model_reset();
      for (int d = 0; d < 4; d++) begin
         for (int i = 0; i < 8; i++) m_age[d][i] = 0;
         m_ptr[d] = 0; m_bus[d] = '0; m_pg[d] = '0; m_ps[d] = '0;
      end
   endtask
   task automatic cyc(input logic [7:0] r, input logic rst);
      logic [7:0]      og, ou;
      logic [2:0][7:0] ob;
      req = r;
      reset = rst;
      #1;
      for (int d = 0; d < 4; d++) begin
         model_eval(d, r, rst, e_g[d], e_u[d], e_p[d], e_l[d]);
         if (d == 3) begin
            og = g8; ou = u8; ob = b8;
         end else begin
            og = {2'b0, g6[d]}; ou = {2'b0, u6[d]};
            for (int k = 0; k < 3; k++) ob[k] = {2'b0, b6[d][k]};
         end
         check("gnt", d, {24'b0, og}, {24'b0, e_g[d]});
         check("urgent", d, {24'b0, ou}, {24'b0, e_u[d]});
         check("gnt_bus", d, {8'b0, ob}, {8'b0, m_bus[d]});
`ifdef CDB_ARB_PERF_EN
         check("perf_grants", d, pg[d], m_pg[d]);
         check("perf_starve", d, ps[d], m_ps[d]);
`else
         check("perf_grants", d, pg[d], 32'd0);
         check("perf_starve", d, ps[d], 32'd0);
`endif
      end
      @(posedge clock);
      if (rst) model_reset();
      else
         for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < cfg_nr[d]; i++)
               m_age[d][i] = (r[i] && !e_g[d][i]) ? (m_age[d][i] < cfg_sl[d] ? m_age[d][i] + 1 : cfg_sl[d]) : 0;
            if (e_l[d] >= 0) m_ptr[d] = (e_l[d] + 1) % cfg_nr[d];
            m_bus[d] = e_p[d];
            m_pg[d] = m_pg[d] + 32'($countones(e_g[d]));
            m_ps[d] = m_ps[d] + {31'b0, |e_u[d]};
         end
      #1;
   endtask
   initial begin
      model_reset();
      cyc(8'hFF, 1'b1);
      cyc(8'hFF, 1'b1);
      for (int c = 0; c < 7; c++) cyc(8'hFF, 1'b0);
      cyc(8'h00, 1'b0);
      cyc(8'h00, 1'b0);
      cyc(8'h00, 1'b1);
      for (int c = 0; c < 3; c++) cyc(8'h20, 1'b0);
      cyc(8'hFF, 1'b0);
      cyc(8'hFF, 1'b0);
      cyc(8'h3F, 1'b1);
      for (int c = 0; c < 4; c++) cyc(8'h3F, 1'b0);
      cyc(8'h3F, 1'b1);
      for (int c = 0; c < 6; c++) cyc(8'h3F, 1'b0);
      cyc(8'h3F, 1'b0);
      cyc(8'h07, 1'b0);
      cyc(8'h3F, 1'b0);
      for (int c = 0; c < 300; c++)
         cyc(8'($urandom_range(0, 255)), $urandom_range(0, 39) == 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
